riscv_mem_arbiter: RTL and testbench

- Shares the single-port synchronous core RAM between two requesters: instruction fetch (IF) and load/store data (D).
- Sits between the pc/decoder datapath and the RAM macro, and drives all RAM control pins.
- Arbitrates one access per cycle, with data priority and an IF starvation guard.
- Returns read data one cycle after grant, tagged to the granted requester.

---
 rtl/riscv_mem_arbiter.sv | 115 +++++++++++
 tb/tb_riscv_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// Single-port core RAM arbiter between instruction fetch (IF) and load/store (D).
// Data has priority; IF is forced through after STARVE_MAX consecutive lost cycles.
module riscv_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                x_reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [3:0]          starve_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] CNT_SAT    = 4'd15;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_own_e;

  rsp_own_e   rsp_own_q, rsp_own_d;
  logic [3:0] starve_q, starve_d;
  logic       force_if_s;

  // Grant selection and RAM pin drive; everything is held at zero while in reset.
  always_comb begin
    force_if_s = 1'b0;
    d_gnt      = 1'b0;
    if_gnt     = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    if (x_reset) begin
      force_if_s = 1'b0;
    end else begin
      force_if_s = if_req & (starve_q >= STARVE_LIM);
      d_gnt      = d_req & ~force_if_s;
      if_gnt     = if_req & ~d_gnt;
      mem_en     = if_gnt | d_gnt;
      if (d_gnt) begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_be    = d_be;
      end else if (if_gnt) begin
        mem_addr  = if_addr;
      end else begin
        mem_we    = 1'b0;
      end
    end
  end

  // Next response owner and IF wait counter (saturates rather than wrapping).
  always_comb begin
    rsp_own_d = RSP_NONE;
    starve_d  = starve_q;
    if (if_gnt) begin
      rsp_own_d = RSP_IF;
    end else if (d_gnt & ~d_we) begin
      rsp_own_d = RSP_D;
    end else begin
      rsp_own_d = RSP_NONE;
    end
    if (~if_req | if_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q == CNT_SAT) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + 4'd1;
    end
  end

  // State registers; reset drops any response still in flight.
  always_ff @(posedge clk or posedge x_reset) begin
    if (x_reset) begin
      rsp_own_q <= RSP_NONE;
      starve_q  <= 4'd0;
    end else begin
      rsp_own_q <= rsp_own_d;
      starve_q  <= starve_d;
    end
  end

  // Steer RAM read data to whichever requester owns this cycle's response.
  always_comb begin
    if_rvalid  = (rsp_own_q == RSP_IF);
    d_rvalid   = (rsp_own_q == RSP_D);
    if_rdata   = if_rvalid ? mem_rdata : '0;
    d_rdata    = d_rvalid ? mem_rdata : '0;
    starve_cnt = starve_q;
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: bench-side RAM, shadow-memory reference model
// checked every cycle, plus hand-computed checks for the documented scenarios.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        x_reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [3:0]  starve_cnt;

  int n_vec = 0;
  int n_err = 0;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .x_reset(x_reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      0:       return 32'h0000_0093;
      1:       return 32'h0000_0113;
      2:       return 32'hCAFE_F00D;
      4:       return 32'h0000_0013;
      8'h80:   return 32'h1122_3344;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM macro: synchronous, one-cycle read latency, byte-masked writes.
  logic [31:0] ram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = init_word(i);
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          mem_rdata <= ram[mem_addr[9:2]];
        end
      end
    end
  end

  // Reference model: shadow memory, IF wait count and the read expected next cycle.
  logic [31:0] shadow [0:255];
  initial begin
    int m_cnt, m_pend;
    logic [31:0] m_pdata, e_ird, e_drd;
    logic e_dg, e_ig, force_if;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    m_cnt = 0; m_pend = 0; m_pdata = 32'h0;
    forever begin
      @(negedge clk);
      if (x_reset) begin
        check("rst_if_gnt", {31'h0, if_gnt}, 32'h0);
        check("rst_d_gnt", {31'h0, d_gnt}, 32'h0);
        check("rst_mem_en", {31'h0, mem_en}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);
        check("rst_starve", {28'h0, starve_cnt}, 32'h0);
        m_cnt = 0; m_pend = 0;
      end else begin
        force_if = if_req && (m_cnt >= 4);
        e_dg = d_req && !force_if;
        e_ig = if_req && !e_dg;
        check("if_gnt", {31'h0, if_gnt}, {31'h0, e_ig});
        check("d_gnt", {31'h0, d_gnt}, {31'h0, e_dg});
        check("mem_en", {31'h0, mem_en}, {31'h0, e_dg || e_ig});
        check("mem_we", {31'h0, mem_we}, {31'h0, e_dg && d_we});
        check("mem_addr", mem_addr, e_dg ? d_addr : (e_ig ? if_addr : 32'h0));
        check("mem_wdata", mem_wdata, e_dg ? d_wdata : 32'h0);
        check("mem_be", {28'h0, mem_be}, e_dg ? {28'h0, d_be} : 32'h0);
        check("starve_cnt", {28'h0, starve_cnt}, m_cnt);
        e_ird = (m_pend == 1) ? m_pdata : 32'h0;
        e_drd = (m_pend == 2) ? m_pdata : 32'h0;
        check("if_rvalid", {31'h0, if_rvalid}, {31'h0, m_pend == 1});
        check("d_rvalid", {31'h0, d_rvalid}, {31'h0, m_pend == 2});
        check("if_rdata", if_rdata, e_ird);
        check("d_rdata", d_rdata, e_drd);
        m_pend = 0;
        if (e_dg && d_we) begin
          for (int b = 0; b < 4; b++)
            if (d_be[b]) shadow[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
        end else if (e_dg) begin
          m_pend = 2; m_pdata = shadow[d_addr[9:2]];
        end else if (e_ig) begin
          m_pend = 1; m_pdata = shadow[if_addr[9:2]];
        end
        if (!if_req || e_ig) m_cnt = 0;
        else if (m_cnt < 15) m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_be = dbe;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    x_reset = 1'b1;
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_rst_gnt", {30'h0, if_gnt, d_gnt}, 32'h0);
    check("hand_rst_mem_en", {31'h0, mem_en}, 32'h0);

    // IF only, first cycle out of reset
    next_cycle();
    x_reset = 1'b0;
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_if_gnt", {31'h0, if_gnt}, 32'h1);
    check("hand_if_mem", {30'h0, mem_en, mem_we}, 32'h2);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_if_rdata", if_rdata, 32'h0000_0013);
    check("hand_if_d_rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h2);

    // D write then IF read of the same word
    next_cycle();
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    check("hand_wr_gnt", {29'h0, d_gnt, if_gnt, mem_we}, 32'h5);
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_wr_if_gnt", {31'h0, if_gnt}, 32'h1);
    check("hand_wr_no_rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_wr_if_rdata", if_rdata, 32'hDEAD_BEEF);

    // Starvation guard with STARVE_MAX=4
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      drive((c <= 4) ? 1'b1 : 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
      @(negedge clk);
      check("hand_stv_cnt", {28'h0, starve_cnt}, (c < 5) ? c : 0);
      check("hand_stv_gnt", {30'h0, d_gnt, if_gnt}, (c == 4) ? 32'h1 : 32'h2);
    end

    // Back-to-back reads IF 0x0, D 0x8, IF 0x4
    next_cycle();
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_b2b_c0", {30'h0, mem_en, if_gnt}, 32'h3);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_b2b_c1", {29'h0, mem_en, d_gnt, if_rvalid}, 32'h7);
    check("hand_b2b_if0", if_rdata, 32'h0000_0093);
    next_cycle();
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_b2b_c2", {29'h0, mem_en, if_gnt, d_rvalid}, 32'h7);
    check("hand_b2b_d8", d_rdata, 32'hCAFE_F00D);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_b2b_if4", if_rdata, 32'h0000_0113);

    // Byte write into 0x11223344, then read back
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h0000_AB00, 4'b0010);
    @(negedge clk);
    check("hand_be", {28'h0, mem_be}, 32'h2);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_be_rdata", d_rdata, 32'h1122_AB44);

    // Reset asserted mid-cycle after a D read grant
    next_cycle();
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_mr_d_gnt", {31'h0, d_gnt}, 32'h1);
    #2;
    x_reset = 1'b1;
    #1;
    check("hand_mr_drop", {29'h0, d_gnt, if_gnt, mem_en}, 32'h0);
    next_cycle();
    next_cycle();
    x_reset = 1'b0;
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_mr_post", {26'h0, starve_cnt, d_rvalid, if_gnt}, 32'h1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("hand_mr_if_rdata", if_rdata, 32'h0000_0013);
    next_cycle();
    next_cycle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
